// File: rtl/hilo_commit_pkg.sv
// Shared definitions for the HI/LO commit stage: instruction codes, FSM states,
// op classes and the decode helpers used by the top and the accumulator.
package hilo_commit_pkg;

  typedef logic [63:0] word_t;

  localparam logic [7:0] INST_MULT  = 8'h18;
  localparam logic [7:0] INST_MULTU = 8'h19;
  localparam logic [7:0] INST_DIV   = 8'h1A;
  localparam logic [7:0] INST_DIVU  = 8'h1B;
  localparam logic [7:0] INST_MADD  = 8'h1C;
  localparam logic [7:0] INST_MADDU = 8'h1D;
  localparam logic [7:0] INST_MSUB  = 8'h1E;
  localparam logic [7:0] INST_MSUBU = 8'h1F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_DIRECT = 2'd0,
    OP_ACC    = 2'd1,
    OP_SUB    = 2'd2
  } op_e;

  function automatic logic is_mc_inst(input logic [7:0] code);
    case (code)
      INST_MULT, INST_MULTU, INST_DIV, INST_DIVU,
      INST_MADD, INST_MADDU, INST_MSUB, INST_MSUBU: is_mc_inst = 1'b1;
      default:                                      is_mc_inst = 1'b0;
    endcase
  endfunction

  function automatic op_e op_class(input logic [7:0] code);
    case (code)
      INST_MADD, INST_MADDU: op_class = OP_ACC;
      INST_MSUB, INST_MSUBU: op_class = OP_SUB;
      default:               op_class = OP_DIRECT;
    endcase
  endfunction

endpackage

// File: rtl/hilo_acc.sv
// Combinational HI/LO update value: pass the raw result, or add/subtract it
// from the current HI/LO (mod 2^64) according to the latched op class.
module hilo_acc
  import hilo_commit_pkg::*;
(
  input  op_e   op_i,
  input  word_t hilo_i,
  input  word_t res_i,
  output word_t val_o
);

  always_comb begin
    val_o = res_i;
    case (op_i)
      OP_ACC:  val_o = hilo_i + res_i;
      OP_SUB:  val_o = hilo_i - res_i;
      default: val_o = res_i;
    endcase
  end

endmodule

// File: rtl/hilo_commit.sv
// EX-stage HI/LO owner: tracks a multi-cycle op, stalls while it runs, commits
// (or accumulates) into HI/LO. Define HILO_FWD_EN for a same-cycle hilo_o bypass.
module hilo_commit
  import hilo_commit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 48,
  parameter int CNT_W          = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue,
  input  logic [7:0]  inst,
  input  logic [63:0] mc_result,
  input  logic        mc_done,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] wdata,
  input  logic        stall_in,
  input  logic        flush,
  output logic [63:0] hilo_o,
  output logic        stall_o,
  output logic        busy,
  output logic        err_timeout
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  word_t            buf_q, buf_d;
  word_t            hilo_q, hilo_d;
  logic             err_q, err_d;
  word_t            acc_val;
  logic             start;

  // Flush wins over a same-cycle issue: nothing is accepted in a flush cycle.
  assign start = issue & is_mc_inst(inst) & ~flush;

  hilo_acc u_acc (
    .op_i   (op_q),
    .hilo_i (hilo_q),
    .res_i  (mc_result),
    .val_o  (acc_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (flush)                    state_d = ST_IDLE;
        else if (mc_done && !stall_in) state_d = ST_IDLE;
        else if (mc_done)             state_d = ST_HOLD;
        else if (cnt_q == TMO)        state_d = ST_IDLE;
      end
      ST_HOLD: if (flush || !stall_in) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    stall_o = busy | start;
  end

  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    buf_d  = buf_q;
    hilo_d = hilo_q;
    err_d  = err_q;
    case (state_q)
      ST_IDLE: begin
        if (!flush) begin
          if (mthi_we) hilo_d[63:32] = wdata;
          if (mtlo_we) hilo_d[31:0]  = wdata;
        end
        if (start) begin
          cnt_d = '0;
          op_d  = op_class(inst);
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush)                     buf_d  = '0;
        else if (mc_done && !stall_in) hilo_d = acc_val;
        else if (mc_done)              buf_d  = acc_val;
        else if (cnt_q == TMO)         err_d  = 1'b1;
      end
      ST_HOLD: begin
        if (flush) begin
          buf_d = '0;
        end else if (!stall_in) begin
          hilo_d = buf_q;
          buf_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      op_q   <= OP_DIRECT;
      buf_q  <= '0;
      hilo_q <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      buf_q  <= buf_d;
      hilo_q <= hilo_d;
      err_q  <= err_d;
    end
  end

`ifdef HILO_FWD_EN
  assign hilo_o = hilo_d;
`else
  assign hilo_o = hilo_q;
`endif

  assign err_timeout = err_q;

endmodule

// File: tb/tb_hilo_commit.sv
// Self-checking bench for hilo_commit: vector table, hand-written corner sequences
// and randomized ops checked against a plain-arithmetic HI/LO model.
module tb_hilo_commit;
  import hilo_commit_pkg::*;

`ifdef HILO_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, issue, mc_done, mthi_we, mtlo_we, stall_in, flush;
  logic [7:0]  inst;
  logic [63:0] mc_result;
  logic [31:0] wdata;
  logic [63:0] hilo_o;
  logic        stall_o, busy, err_timeout;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] model_hilo = '0;
  logic [7:0]  ops [8];

  typedef struct {
    logic [7:0]  op;
    logic [63:0] init;
    logic [63:0] res;
    int          lat;
    int          hold;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs [7];

  hilo_commit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue       (issue),
    .inst        (inst),
    .mc_result   (mc_result),
    .mc_done     (mc_done),
    .mthi_we     (mthi_we),
    .mtlo_we     (mtlo_we),
    .wdata       (wdata),
    .stall_in    (stall_in),
    .flush       (flush),
    .hilo_o      (hilo_o),
    .stall_o     (stall_o),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Architectural meaning of each instruction, independent of any FSM detail.
  function automatic logic [63:0] ref_op(input logic [7:0] op, input logic [63:0] cur,
                                         input logic [63:0] r);
    if (op == INST_MADD || op == INST_MADDU) return cur + r;
    if (op == INST_MSUB || op == INST_MSUBU) return cur - r;
    return r;
  endfunction

  task automatic idle_inputs();
    issue = 0; mc_done = 0; mthi_we = 0; mtlo_we = 0; stall_in = 0; flush = 0;
  endtask

  task automatic mt_write(input bit hi, input bit lo, input logic [31:0] d);
    logic [63:0] nv;
    nv = model_hilo;
    if (hi) nv[63:32] = d;
    if (lo) nv[31:0]  = d;
    @(negedge clk);
    mthi_we = hi; mtlo_we = lo; wdata = d;
    #1;
    check64("mt_bypass", hilo_o, FWD ? nv : model_hilo);
    model_hilo = nv;
    @(negedge clk);
    mthi_we = 0; mtlo_we = 0;
    #1;
    check64("mt_commit", hilo_o, model_hilo);
  endtask

  task automatic do_op(input logic [7:0] op, input logic [63:0] res, input int lat,
                       input int hold, input bit noise, output int stalls);
    logic [63:0] nv;
    nv = ref_op(op, model_hilo, res);
    @(negedge clk);
    issue = 1; inst = op;
    #1;
    check1("stall_on_issue", stall_o, 1'b1);
    stalls = stall_o ? 1 : 0;
    for (int c = 1; c <= lat + hold + 2; c++) begin
      @(negedge clk);
      inst      = ops[$urandom_range(0, 7)];
      issue     = noise && c == 2 && c < lat;
      mthi_we   = noise && c == 3 && c < lat;
      mtlo_we   = noise && c == 3 && c < lat;
      wdata     = $urandom;
      mc_done   = (c == lat);
      mc_result = (c == lat) ? res : {$urandom, $urandom};
      stall_in  = (c >= lat) && (c < lat + hold);
      #1;
      if (stall_o) stalls++;
      if (c == lat && hold == 0) check64("commit_bypass", hilo_o, FWD ? nv : model_hilo);
      if (hold >= 2 && c == lat + 1) begin
        check1("hold_busy", busy, 1'b1);
        check64("hold_hilo", hilo_o, model_hilo);
      end
    end
    idle_inputs();
    model_hilo = nv;
    check64("op_result", hilo_o, model_hilo);
    check1("op_idle", busy, 1'b0);
  endtask

  initial begin
    int stalls;
    ops = '{INST_DIV, INST_DIVU, INST_MULT, INST_MULTU,
            INST_MADD, INST_MADDU, INST_MSUB, INST_MSUBU};
    vecs[0] = '{INST_DIVU,  64'h0,                   64'h00000001_00000003, 36, 0, 64'h00000001_00000003};
    vecs[1] = '{INST_MADD,  64'h1,                   64'hFFFFFFFF_FFFFFFFF,  5, 0, 64'h0};
    vecs[2] = '{INST_MSUB,  64'h0,                   64'h1,                  4, 0, 64'hFFFFFFFF_FFFFFFFF};
    vecs[3] = '{INST_MADDU, 64'h00000000_FFFFFFFF,   64'h1,                  3, 3, 64'h00000001_00000000};
    vecs[4] = '{INST_MSUBU, 64'h00000001_00000000,   64'h1,                  2, 2, 64'h00000000_FFFFFFFF};
    vecs[5] = '{INST_MULT,  64'h12345678_9ABCDEF0,   64'hCAFEBABE_00000001,  1, 0, 64'hCAFEBABE_00000001};
    vecs[6] = '{INST_DIV,   64'h0BAD0BAD_0BAD0BAD,   64'h00000007_00000002, 36, 1, 64'h00000007_00000002};

    rst_n = 0; inst = 8'h0; mc_result = '0; wdata = '0;
    idle_inputs();
    #1;
    check64("reset_hilo", hilo_o, 64'h0);
    check1("reset_stall", stall_o, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_err", err_timeout, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    foreach (vecs[i]) begin
      mt_write(1, 0, vecs[i].init[63:32]);
      mt_write(0, 1, vecs[i].init[31:0]);
      do_op(vecs[i].op, vecs[i].res, vecs[i].lat, vecs[i].hold, 1'b0, stalls);
      check64("tbl_result", hilo_o, vecs[i].exp);
      checki("tbl_stall_cycles", stalls, vecs[i].lat + vecs[i].hold + 1);
    end

    mt_write(1, 1, 32'h11111111);
    mt_write(1, 0, 32'hDEADBEEF);
    check64("mthi_hi", {32'd0, hilo_o[63:32]}, {32'd0, 32'hDEADBEEF});
    check64("mthi_lo_kept", {32'd0, hilo_o[31:0]}, {32'd0, 32'h11111111});
    mt_write(1, 1, 32'h5A5A0F0F);

    // Flush in the same cycle as mc_done: no commit.
    @(negedge clk);
    issue = 1; inst = INST_MADD;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      issue = 0;
      mc_done = (c == 10); flush = (c == 10); mc_result = {$urandom, $urandom};
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check1("flush_done_stall", stall_o, 1'b0);
    check1("flush_done_busy", busy, 1'b0);
    check64("flush_done_hilo", hilo_o, model_hilo);

    // Flush while holding a buffered result: buffer discarded.
    @(negedge clk);
    issue = 1; inst = INST_MSUB;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      issue = 0;
      mc_done = (c == 3); mc_result = 64'h5;
      stall_in = (c >= 3 && c <= 5);
      flush = (c == 4);
      #1;
      if (c == 5) check1("flush_hold_busy", busy, 1'b0);
    end
    idle_inputs();
    check64("flush_hold_hilo", hilo_o, model_hilo);

    // MTHI in a flush cycle is dropped.
    @(negedge clk);
    mthi_we = 1; flush = 1; wdata = 32'hFEEDFACE;
    @(negedge clk);
    idle_inputs();
    #1;
    check64("flush_mthi_dropped", hilo_o, model_hilo);

    // Timeout: DIV with no done ever.
    mt_write(1, 1, 32'hA5A5A5A5);
    @(negedge clk);
    issue = 1; inst = INST_DIV;
    for (int c = 1; c <= 52; c++) begin
      @(negedge clk);
      issue = 0;
      #1;
      if (c == 45) begin
        check1("tmo_not_yet", err_timeout, 1'b0);
        check1("tmo_still_busy", busy, 1'b1);
      end
      if (c == 50) begin
        check1("tmo_err", err_timeout, 1'b1);
        check1("tmo_idle", busy, 1'b0);
        check1("tmo_stall", stall_o, 1'b0);
      end
    end
    check64("tmo_hilo", hilo_o, model_hilo);
    do_op(INST_MULT, 64'h00000042_00000099, 6, 0, 1'b0, stalls);
    check1("tmo_sticky", err_timeout, 1'b1);

    for (int n = 0; n < 25; n++) begin
      logic [7:0] op;
      int lat, hold;
      bit hi, lo;
      if ($urandom_range(0, 2) == 0) begin
        hi = 1'($urandom_range(0, 1));
        lo = hi ? 1'($urandom_range(0, 1)) : 1'b1;
        mt_write(hi, lo, $urandom);
      end
      op   = ops[$urandom_range(0, 7)];
      lat  = int'($urandom_range(1, 40));
      hold = int'($urandom_range(0, 3));
      do_op(op, {$urandom, $urandom}, lat, hold, 1'b1, stalls);
      checki("rnd_stall_cycles", stalls, lat + hold + 1);
    end

    // Reset in the middle of a run.
    mt_write(0, 1, 32'h00000077);
    @(negedge clk);
    issue = 1; inst = INST_MULTU;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      issue = 0;
    end
    rst_n = 0;
    #1;
    check64("midrst_hilo", hilo_o, 64'h0);
    check1("midrst_stall", stall_o, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_err", err_timeout, 1'b0);
    model_hilo = '0;
    @(negedge clk);
    rst_n = 1;
    do_op(INST_MADDU, 64'h00000003_00000004, 8, 1, 1'b0, stalls);
    check64("post_rst_acc", hilo_o, 64'h00000003_00000004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_commit.md
Name: hilo_commit

Overview:
- EX-stage companion to the multi-cycle MUL/DIV unit. Sits directly downstream of it and owns the architectural HI/LO pair.
- Tracks each multi-cycle op from issue to done and stalls the pipeline while the op runs.
- Performs the MADD/MADDU/MSUB/MSUBU accumulate against HI/LO.
- Commits the result into HI/LO and feeds the current HI/LO value back to the multi-cycle unit and to MFHI/MFLO.

Parameters:
TIMEOUT_CYCLES, 48, RUN-state cycle limit before err_timeout sets (must exceed the divider latency of 36).
CNT_W, 6, width of the RUN cycle counter; 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
issue  in  1  EX holds a valid multi-cycle inst this cycle
inst  in  8  instruction code (INST_* from defs)
mc_result  in  64  multi-cycle result {hi,lo}; raw product for MADD/MSUB class
mc_done  in  1  multi-cycle result valid
mthi_we  in  1  MTHI write
mtlo_we  in  1  MTLO write
wdata  in  32  MTHI/MTLO data
stall_in  in  1  downstream (MEM) stall; commit must wait
flush  in  1  exception flush; abort in-flight op
hilo_o  out  64  architectural {HI,LO}
stall_o  out  1  stall request to pipeline control
busy  out  1  op in flight (RUN or HOLD)
err_timeout  out  1  sticky; RUN exceeded TIMEOUT_CYCLES

Behaviour:
- Reset values: hilo_o=0, stall_o=0, busy=0, err_timeout=0, state=IDLE, counter=0, holding buffer=0.
- Op classes:
  - DIRECT = DIV/DIVU/MULT/MULTU: new HI/LO = mc_result.
  - ACC = MADD/MADDU: new HI/LO = HI/LO + mc_result, mod 2^64.
  - SUB = MSUB/MSUBU: new HI/LO = HI/LO - mc_result, mod 2^64.
  - inst is latched at issue; later changes to inst are ignored until IDLE.
- FSM states:
  - IDLE:
    - issue with a multi-cycle inst -> RUN, counter=0, stall_o=1 from the same cycle (combinational on issue).
    - MTHI/MTLO update only the selected half on the next edge.
  - RUN: stall_o=1; counter increments each cycle.
    - mc_done & !stall_in -> commit on this edge, go to IDLE; stall_o=0 the next cycle.
    - mc_done & stall_in -> capture the computed value in the holding buffer, go to HOLD.
    - counter==TIMEOUT_CYCLES -> set err_timeout, go to IDLE, no commit.
  - HOLD: stall_o=1.
    - !stall_in -> commit the buffer, go to IDLE.
- Latency: HI/LO is visible on hilo_o one cycle after the mc_done edge when there is no stall.
- flush:
  - In any state, flush -> IDLE on the next edge with no commit; the buffer is discarded.
  - flush takes priority over mc_done in the same cycle.
  - MTHI/MTLO in the flush cycle is dropped.
- mthi_we/mtlo_we while busy: ignored. The pipeline is stalled, so this is illegal; the assertion bench flags it.
- issue while busy: ignored.
- Both mthi_we and mtlo_we in one cycle: both halves written with wdata.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); no partial commit.
- err_timeout: cleared only by reset.

Optional Feature:
HILO_FWD_EN.
- Defined: hilo_o is a combinational bypass, showing the value being committed (or MTHI/MTLO data) in the same cycle as the write. MFHI directly after a commit sees the new value with zero bubble.
- Undefined: hilo_o is the registered value only; the new value is visible one cycle after the write edge.

Decomposition:
- Shared package/defs: INST_DIV/DIVU/MULT/MULTU/MADD/MADDU/MSUB/MSUBU codes, FSM state encodings (IDLE=2'd0, RUN=2'd1, HOLD=2'd2), and a 64-bit word typedef.
- One natural sub-module: hilo_acc, the combinational 64-bit add/sub/pass selector by op class. It is reused for the HOLD buffer and the bypass path.

Test Plan:
- DIVU: HI/LO=0, issue inst=INST_DIVU, mc_result=64'h00000001_00000003 with mc_done after 36 cycles -> stall_o high for 37 cycles; hilo_o=64'h00000001_00000003 one cycle after done.
- MADD: HI/LO=64'h1, mc_result=64'hFFFF_FFFF_FFFF_FFFF -> hilo_o=0 (wrap-around). MSUB: HI/LO=0, mc_result=1 -> hilo_o=64'hFFFF_FFFF_FFFF_FFFF.
- Stall: mc_done while stall_in=1 for 3 cycles -> state HOLD, hilo_o unchanged; commit on the cycle after stall_in falls, value correct.
- Flush: flush in the same cycle as mc_done -> no commit, IDLE, stall_o=0 the next cycle. Reset asserted mid-RUN -> all outputs 0 immediately.
- Timeout: issue inst=INST_DIV, never assert mc_done -> err_timeout=1 after 48 RUN cycles, stays 1 until reset, hilo_o unchanged.
- MTHI/MTLO: mthi_we with wdata=32'hDEADBEEF -> hilo_o[63:32]=DEADBEEF, LO unchanged. With HILO_FWD_EN, the value appears in the same cycle; without it, the next cycle.
